// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse BRAM reader: fp32 field constants,
// default address stride and the reader FSM encoding.
package pulse_pkg;

  localparam int EXP_BIAS      = 127;
  localparam int MANT_W        = 23;
  localparam int EXP_MAX       = 255;
  localparam int ADDR_STEP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CLEAR,
    ST_PRESENT
  } state_t;

endpackage

// File: rtl/pulse_bram_reader_if.sv
// BRAM port B and sample stream bundle; master is the reader, slave is the
// BRAM plus downstream consumer side.
interface pulse_bram_reader_if #(
  parameter int OUT_W = 16
);

  logic [31:0]      bram_addr_rd;
  logic [31:0]      bram_data_in_rd;
  logic             bram_we_rd;
  logic             ena_rd;
  logic [31:0]      bram_data_out_rd;
  logic [OUT_W-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready;
  logic             sample_last;

  modport master (
    output bram_addr_rd, bram_data_in_rd, bram_we_rd, ena_rd,
    input  bram_data_out_rd,
    output sample_data, sample_valid, sample_last,
    input  sample_ready
  );

  modport slave (
    input  bram_addr_rd, bram_data_in_rd, bram_we_rd, ena_rd,
    output bram_data_out_rd,
    input  sample_data, sample_valid, sample_last,
    output sample_ready
  );

endinterface

// File: rtl/fp32_to_ufix.sv
// Combinational fp32 -> unsigned fixed point (truncating), zero latency.
// Negatives, zero/denormals and NaN give 0; inf and overflow saturate.
module fp32_to_ufix
  import pulse_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 12
) (
  input  logic [31:0]      i_fp,
  output logic [OUT_W-1:0] o_fix
);

  localparam int WW     = MANT_W + 1 + OUT_W;
  localparam int SH_OFF = FRAC_BITS - EXP_BIAS - MANT_W;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [MANT_W-1:0]  w_mant;
  logic [MANT_W:0]    w_sig;
  logic signed [31:0] w_sh;
  logic [WW-1:0]      w_wide;
  logic [OUT_W-1:0]   w_max;

  assign w_sign = i_fp[31];
  assign w_exp  = i_fp[30:23];
  assign w_mant = i_fp[22:0];
  assign w_sig  = {1'b1, w_mant};
  assign w_sh   = $signed({24'd0, w_exp}) + SH_OFF;
  assign w_max  = '1;

  // Shift amounts are range-checked before shifting so w_wide never loses bits.
  always_comb begin
    w_wide = '0;
    o_fix  = '0;
    if (w_sign || (w_exp == 8'd0)) begin
      o_fix = '0;
    end else if (w_exp == 8'(EXP_MAX)) begin
      o_fix = (w_mant != '0) ? '0 : w_max;
    end else if (w_sh >= OUT_W) begin
      o_fix = w_max;
    end else if (w_sh >= 0) begin
      w_wide = WW'(w_sig) << w_sh;
      o_fix  = (|w_wide[WW-1:OUT_W]) ? w_max : w_wide[OUT_W-1:0];
    end else if (w_sh <= -(MANT_W + 1)) begin
      o_fix = '0;
    end else begin
      w_wide = WW'(w_sig) >> (-w_sh);
      o_fix  = (|w_wide[WW-1:OUT_W]) ? w_max : w_wide[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pulse_bram_reader.sv
// Sweeps the pulse BRAM, converts fp32 words to fixed point and streams them;
// 4 cycles/sample with clear (3 without), holds the sample while ready is low.
module pulse_bram_reader
  import pulse_pkg::*;
#(
  parameter int DEPTH         = 1024,
  parameter int ADDR_STEP     = ADDR_STEP_DEF,
  parameter int OUT_W         = 16,
  parameter int FRAC_BITS     = 12,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  pulse_bram_reader_if.master bus,
  output logic                frame_done,
  output logic                busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [31:0]      r_addr;
  logic             r_ena;
  logic             r_we;
  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             r_busy;

  logic [OUT_W-1:0] w_fix;
  logic             w_is_last;
  logic [IW-1:0]    w_idx_nxt;

  fp32_to_ufix #(
    .OUT_W     (OUT_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_conv (
    .i_fp  (bus.bram_data_out_rd),
    .o_fix (w_fix)
  );

  function automatic logic [31:0] addr_of(input logic [IW-1:0] idx);
    return 32'(idx) * 32'(ADDR_STEP);
  endfunction

  assign w_is_last = (r_idx == IW'(DEPTH - 1));
  assign w_idx_nxt = w_is_last ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_ena   <= 1'b0;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_READ;
            r_ena   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= addr_of(r_idx);
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          r_ena   <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_data <= w_fix;
          r_last <= w_is_last;
          if (CLEAR_ON_READ != 0) begin
            r_state <= ST_CLEAR;
            r_ena   <= 1'b1;
            r_we    <= 1'b1;
          end else begin
            r_state <= ST_PRESENT;
            r_valid <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_ena   <= 1'b0;
          r_we    <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.sample_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= w_is_last;
            // A dropped run always resumes from word 0.
            if (en) begin
              r_idx   <= w_idx_nxt;
              r_addr  <= addr_of(w_idx_nxt);
              r_ena   <= 1'b1;
              r_state <= ST_READ;
            end else begin
              r_idx   <= '0;
              r_addr  <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ena   <= 1'b0;
          r_we    <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bram_addr_rd    = r_addr;
  assign bus.bram_data_in_rd = '0;
  assign bus.bram_we_rd      = r_we;
  assign bus.ena_rd          = r_ena;
  assign bus.sample_data     = r_data;
  assign bus.sample_valid    = r_valid;
  assign bus.sample_last     = r_last;
  assign frame_done          = r_done;
  assign busy                = r_busy;

endmodule
